madd_seq_ctrl: RTL and testbench

//   Sequencer for the DMADD multiply-add datapath. Buffers a short program of
//   {insn,index,data} commands, then drives DMADD's load/run/insn/index/data pins
//   one entry at a time. Captures each 12-bit result and returns it over a

---
 rtl/madd_seq_ctrl_if.sv | 26 ++
 rtl/madd_seq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_madd_seq_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/madd_seq_ctrl_if.sv
// Command / result handshake bundle between a DMADD program source and madd_seq_ctrl.
// cmd_data packs {insn[9:8], index[7:4], data[3:0]}; res_tag is the buffer slot of the producing entry.
interface madd_seq_ctrl_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned OUT_W = 12
) ();
  localparam int unsigned TAG_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [9:0]       cmd_data;
  logic             res_valid;
  logic             res_ready;
  logic [OUT_W-1:0] res_data;
  logic [TAG_W-1:0] res_tag;

  modport master (
    output cmd_valid, cmd_data, res_ready,
    input  cmd_ready, res_valid, res_data, res_tag
  );

  modport slave (
    input  cmd_valid, cmd_data, res_ready,
    output cmd_ready, res_valid, res_data, res_tag
  );
endinterface

// File: rtl/madd_seq_ctrl.sv
// Buffered program sequencer for the DMADD multiply-add datapath.
// Define MADD_SEQ_LOOP_EN to retain entries and replay the program until a stop request.
module madd_seq_ctrl #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned RUN_CYCLES = 4,
  parameter int unsigned OUT_W      = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  madd_seq_ctrl_if.slave   bus,
  input  logic             start,
  input  logic             flush,
  output logic             busy,
  output logic             err,
  output logic             madd_load,
  output logic             madd_run,
  output logic [1:0]       madd_insn,
  output logic [3:0]       madd_index,
  output logic [3:0]       madd_data,
  input  logic [OUT_W-1:0] madd_out
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned RC_W  = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_CAPT, S_EMIT} state_t;

  state_t           state, state_n;
  logic [PTR_W-1:0] wr_ptr, wr_n, rd_ptr, rd_n, nxt_ptr;
  logic [CNT_W-1:0] count, cnt_n;
  logic [RC_W-1:0]  run_cnt, rc_n;
  logic             stop_req, stop_n, err_n, rv_n, wr_en;
  logic             load_n, run_n;
  logic [OUT_W-1:0] rdat_n;
  logic [PTR_W-1:0] tag_n;
  logic [9:0]       head_n, pins_n;
  logic [9:0]       mem [DEPTH];
`ifdef MADD_SEQ_LOOP_EN
  logic [PTR_W-1:0] oldest;
`endif

  // Next-state and next-output logic; every output below is registered from these.
  always_comb begin
    state_n = state;
    wr_n    = wr_ptr;
    rd_n    = rd_ptr;
    cnt_n   = count;
    rc_n    = run_cnt;
    stop_n  = stop_req;
    err_n   = err;
    rv_n    = bus.res_valid;
    rdat_n  = bus.res_data;
    tag_n   = bus.res_tag;
    wr_en   = 1'b0;
    nxt_ptr = rd_ptr + PTR_W'(1);
`ifdef MADD_SEQ_LOOP_EN
    oldest  = wr_ptr - count[PTR_W-1:0];
    if (state != S_IDLE && start) stop_n = 1'b1;
`endif
    case (state)
      S_IDLE: begin
        stop_n = 1'b0;
        if (flush) begin
          cnt_n = '0;
          wr_n  = '0;
          rd_n  = '0;
        end else begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            wr_en = 1'b1;
            wr_n  = wr_ptr + PTR_W'(1);
            cnt_n = count + CNT_W'(1);
          end
          if (start) begin
            if (cnt_n != '0) state_n = S_LOAD;
            else             err_n   = 1'b1;
          end
        end
      end
      S_LOAD: begin
        rc_n    = '0;
        state_n = S_RUN;
      end
      S_RUN: begin
        if (run_cnt == RC_W'(RUN_CYCLES - 1)) state_n = S_CAPT;
        else                                  rc_n    = run_cnt + RC_W'(1);
      end
      S_CAPT: begin
        rv_n    = 1'b1;
        rdat_n  = madd_out;
        tag_n   = rd_ptr;
        state_n = S_EMIT;
      end
      S_EMIT: begin
        if (bus.res_ready) begin
          rv_n = 1'b0;
`ifdef MADD_SEQ_LOOP_EN
          // Past the newest entry the program rewinds to the oldest one.
          if (nxt_ptr == wr_ptr) nxt_ptr = oldest;
          if (stop_n) begin
            rd_n    = oldest;
            stop_n  = 1'b0;
            state_n = S_IDLE;
          end else begin
            rd_n    = nxt_ptr;
            state_n = S_LOAD;
          end
`else
          rd_n    = nxt_ptr;
          cnt_n   = count - CNT_W'(1);
          state_n = (cnt_n != '0) ? S_LOAD : S_IDLE;
`endif
        end
      end
      default: state_n = S_IDLE;
    endcase

    // A command written in the same cycle as start is not in mem yet.
    head_n = (wr_en && rd_n == wr_ptr) ? bus.cmd_data : mem[rd_n];
    load_n = (state_n == S_LOAD);
    run_n  = (state_n == S_RUN);
    pins_n = (load_n || run_n) ? head_n : 10'd0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.cmd_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      run_cnt       <= '0;
      stop_req      <= 1'b0;
      err           <= 1'b0;
      busy          <= 1'b0;
      bus.cmd_ready <= 1'b0;
      madd_load     <= 1'b0;
      madd_run      <= 1'b0;
      madd_insn     <= '0;
      madd_index    <= '0;
      madd_data     <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_tag   <= '0;
    end else begin
      state         <= state_n;
      wr_ptr        <= wr_n;
      rd_ptr        <= rd_n;
      count         <= cnt_n;
      run_cnt       <= rc_n;
      stop_req      <= stop_n;
      err           <= err_n;
      busy          <= (state_n != S_IDLE);
      bus.cmd_ready <= (state_n == S_IDLE) && (cnt_n < CNT_W'(DEPTH));
      madd_load     <= load_n;
      madd_run      <= run_n;
      madd_insn     <= pins_n[9:8];
      madd_index    <= pins_n[7:4];
      madd_data     <= pins_n[3:0];
      bus.res_valid <= rv_n;
      bus.res_data  <= rdat_n;
      bus.res_tag   <= tag_n;
    end
  end
endmodule

// File: tb/tb_madd_seq_ctrl.sv
// Self-checking bench for madd_seq_ctrl: timeline reference model, DMADD stub, directed + random stimulus.
// Build with +define+MADD_SEQ_LOOP_EN to exercise the looping configuration.
module tb_madd_seq_ctrl;
  localparam int D = 8;
  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic        busy, err, madd_load, madd_run;
  logic [1:0]  madd_insn;
  logic [3:0]  madd_index, madd_data;
  logic [11:0] madd_out;

  madd_seq_ctrl_if #(.DEPTH(D), .OUT_W(12)) bus ();

  madd_seq_ctrl #(.DEPTH(D), .RUN_CYCLES(R), .OUT_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .start(start), .flush(flush),
    .busy(busy), .err(err), .madd_load(madd_load), .madd_run(madd_run),
    .madd_insn(madd_insn), .madd_index(madd_index), .madd_data(madd_data),
    .madd_out(madd_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // DMADD stand-in: result is only correct after exactly R run cycles following a load.
  logic [9:0] stub_lat = '0;
  int         stub_runs = 0;
  always @(posedge clk) begin
    if (madd_load) begin
      stub_lat  <= {madd_insn, madd_index, madd_data};
      stub_runs <= 0;
    end else if (madd_run) begin
      stub_runs <= stub_runs + 1;
    end
  end
  assign madd_out = (stub_runs == R) ? (12'(stub_lat) ^ 12'h386) : 12'hBAD;

  // Reference model: buffer contents plus a position t along the per-entry timeline.
  logic [9:0]  mbuf [D];
  int          m_wr, m_rd, m_cnt, m_t, m_tag;
  bit          m_act, m_stop, m_err, m_rv, m_rdy, m_started = 0;
  logic [11:0] m_rdat;

  always @(posedge clk) begin
    bit acc;
    int nxt, old;
    m_started = 1;
    if (!rst_n) begin
      m_wr = 0; m_rd = 0; m_cnt = 0; m_t = 0; m_tag = 0;
      m_act = 0; m_stop = 0; m_err = 0; m_rv = 0; m_rdy = 0; m_rdat = '0;
    end else begin
      acc = bus.cmd_valid && m_rdy;
      if (!m_act) begin
        m_stop = 0;
        if (flush) begin
          m_cnt = 0; m_wr = 0; m_rd = 0;
        end else begin
          if (acc) begin
            mbuf[m_wr] = bus.cmd_data;
            m_wr = (m_wr + 1) % D;
            m_cnt++;
          end
          if (start) begin
            if (m_cnt > 0) begin m_act = 1; m_t = 0; end
            else m_err = 1;
          end
        end
      end else begin
`ifdef MADD_SEQ_LOOP_EN
        if (start) m_stop = 1;
`endif
        if (m_t < R + 1) m_t++;
        else if (m_t == R + 1) begin
          m_rv = 1; m_rdat = 12'(mbuf[m_rd]) ^ 12'h386; m_tag = m_rd; m_t++;
        end else if (bus.res_ready) begin
          m_rv = 0;
`ifdef MADD_SEQ_LOOP_EN
          old = (m_wr - m_cnt + D) % D;
          nxt = (m_rd + 1) % D;
          if (nxt == m_wr) nxt = old;
          if (m_stop) begin m_rd = old; m_act = 0; m_stop = 0; end
          else begin m_rd = nxt; m_t = 0; end
`else
          nxt = 0; old = 0;
          m_rd = (m_rd + 1) % D;
          m_cnt--;
          if (m_cnt > 0) m_t = 0; else m_act = 0;
`endif
        end
      end
      m_rdy = !m_act && (m_cnt < D);
    end
  end

  // Per-cycle compare of every DUT output against the model.
  always @(negedge clk) begin
    if (m_started) begin
      bit ld, rn;
      logic [9:0] pins;
      ld = m_act && (m_t == 0);
      rn = m_act && (m_t >= 1) && (m_t <= R);
      pins = (ld || rn) ? mbuf[m_rd] : 10'd0;
      chk("busy", 32'(busy), 32'(m_act));
      chk("err", 32'(err), 32'(m_err));
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(m_rdy));
      chk("madd_load", 32'(madd_load), 32'(ld));
      chk("madd_run", 32'(madd_run), 32'(rn));
      chk("madd_pins", 32'({madd_insn, madd_index, madd_data}), 32'(pins));
      chk("res_valid", 32'(bus.res_valid), 32'(m_rv));
      chk("res_data", 32'(bus.res_data), 32'(m_rdat));
      chk("res_tag", 32'(bus.res_tag), 32'(m_tag));
    end
  end

  // Observed result handshakes.
  int dut_hs = 0;
  int tagq[$];
  always @(posedge clk) begin
    if (rst_n && bus.res_valid && bus.res_ready) begin
      dut_hs++;
      tagq.push_back(int'(bus.res_tag));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [9:0] c);
    bus.cmd_valid = 1'b1; bus.cmd_data = c;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin step(); k++; end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_hs(input int target, input int budget);
    int k = 0;
    while (dut_hs < target && k < budget) begin step(); k++; end
    chk("result_timeout", 32'(dut_hs >= target), 32'd1);
  endtask

  task automatic finish_run();
`ifdef MADD_SEQ_LOOP_EN
    if (busy) start_pulse();
`endif
    wait_idle(300);
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, 32'({busy, err, bus.cmd_ready, madd_load, madd_run, madd_insn, madd_index,
                 madd_data, bus.res_valid}), 32'd0);
    chk(nm, 32'({bus.res_data, bus.res_tag}), 32'd0);
  endtask

  initial begin
    int hs0, k;
    logic [11:0] d0;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_data = '0; bus.res_ready = 1'b0;
    repeat (3) step();
    chk_all_zero("reset_outputs");
    rst_n = 1'b1;
    step();
    chk("ready_after_reset", 32'(bus.cmd_ready), 32'd1);

    // Single entry, full timeline with literal expectations.
    push(10'h2A5);
    start_pulse();
    chk("t2_load", 32'({madd_load, madd_run, madd_insn, madd_index, madd_data}),
        32'({1'b1, 1'b0, 2'd2, 4'hA, 4'h5}));
    for (int i = 0; i < R; i++) begin
      step();
      chk("t2_run", 32'({madd_load, madd_run, madd_insn, madd_index, madd_data}),
          32'({1'b0, 1'b1, 2'd2, 4'hA, 4'h5}));
    end
    step();
    chk("t2_capt", 32'({madd_run, bus.res_valid, madd_insn}), 32'd0);
    step();
    chk("t2_valid", 32'(bus.res_valid), 32'd1);
    chk("t2_data", 32'(bus.res_data), 32'h123);
    chk("t2_tag", 32'(bus.res_tag), 32'd0);
    bus.res_ready = 1'b1;
    step();
    chk("t2_valid_drop", 32'(bus.res_valid), 32'd0);
`ifndef MADD_SEQ_LOOP_EN
    chk("t2_idle", 32'(busy), 32'd0);
`endif

    // Reset in the middle of a run abandons the entry.
    if (bus.cmd_ready) begin push(10'h155); start_pulse(); end
    step(); step();
    hs0 = dut_hs;
    rst_n = 1'b0;
    step();
    chk_all_zero("t1_reset_midrun");
    step();
    rst_n = 1'b1;
    step();
    chk("t1_ready", 32'(bus.cmd_ready), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_no_result", 32'(dut_hs), 32'(hs0));

    // Backpressure in EMIT.
    bus.res_ready = 1'b0;
    push(10'($urandom));
    start_pulse();
    k = 0;
    while (!bus.res_valid && k < 20) begin step(); k++; end
    chk("t4_valid", 32'(bus.res_valid), 32'd1);
    d0 = bus.res_data;
    repeat (5) begin
      step();
      chk("t4_hold", 32'({bus.res_valid, madd_load, madd_run, bus.res_data}), 32'({3'b100, d0}));
    end
    bus.res_ready = 1'b1;
    step();
    finish_run();

    // Start with empty buffer, then cmd+start in the same cycle.
    flush = 1'b1; step(); flush = 1'b0;
    start_pulse();
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    hs0 = dut_hs;
    bus.cmd_valid = 1'b1; bus.cmd_data = 10'($urandom); start = 1'b1;
    step();
    bus.cmd_valid = 1'b0; start = 1'b0;
    chk("t5_busy_run", 32'(busy), 32'd1);
    wait_hs(hs0 + 1, 40);
    finish_run();
`ifndef MADD_SEQ_LOOP_EN
    chk("t5_one_result", 32'(dut_hs - hs0), 32'd1);
`endif

    // Fill to full, ninth command held off, run the whole program.
    flush = 1'b1; step(); flush = 1'b0;
    for (int i = 0; i < D; i++) begin
      chk("t3_ready", 32'(bus.cmd_ready), 32'd1);
      push(10'($urandom));
    end
    chk("t3_full", 32'(bus.cmd_ready), 32'd0);
    bus.cmd_valid = 1'b1; bus.cmd_data = 10'h3FF;
    step(); step();
    chk("t3_held", 32'(bus.cmd_ready), 32'd0);
    bus.cmd_valid = 1'b0;
    hs0 = dut_hs;
    tagq.delete();
    start_pulse();
    wait_hs(hs0 + D, D * (R + 3) + 20);
    finish_run();
    for (int i = 0; i < D; i++)
      chk("t3_tag", 32'((tagq.size() > i) ? tagq[i] : -1), 32'(i));
`ifndef MADD_SEQ_LOOP_EN
    chk("t3_count", 32'(dut_hs - hs0), 32'(D));
`endif

`ifdef MADD_SEQ_LOOP_EN
    // Looping program with stop request, then flush.
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    push(10'h0F1); push(10'h2C3);
    hs0 = dut_hs;
    tagq.delete();
    start_pulse();
    wait_hs(hs0 + 3, 40);
    k = 0;
    while (!madd_run && k < 20) begin step(); k++; end
    start_pulse();
    wait_idle(40);
    chk("t6_tags_n", 32'(tagq.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("t6_tag", 32'((tagq.size() > i) ? tagq[i] : -1), 32'(i % 2));
    chk("t6_model_cnt", 32'(m_cnt), 32'd2);
    hs0 = dut_hs;
    start_pulse();
    wait_hs(hs0 + 1, 20);
    chk("t6_rewound", 32'(tagq[tagq.size()-1]), 32'd0);
    finish_run();
    flush = 1'b1; step(); flush = 1'b0;
    chk("t6_model_flush", 32'(m_cnt), 32'd0);
    start_pulse();
    chk("t6_empty_err", 32'({err, busy}), 32'b10);
`endif

    // Random traffic, model-checked every cycle.
    for (int i = 0; i < 3000; i++) begin
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd_data  = 10'($urandom);
      start         = ($urandom_range(0, 15) == 0);
      flush         = ($urandom_range(0, 39) == 0);
      bus.res_ready = ($urandom_range(0, 3) != 0);
      rst_n         = ($urandom_range(0, 499) != 0);
      step();
    end
    rst_n = 1'b1; start = 1'b0; flush = 1'b0; bus.cmd_valid = 1'b0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
